// File: rtl/flow_snapshot_ctrl.sv
// Capture controller for the parser status CSR window: arms, freezes and releases a parser-result snapshot.
// Build option: define FLOW_SNAP_IRQ_EN to implement CTRL.IRQ_EN and a level irq while the snapshot is held.
module flow_snapshot_ctrl #(
  parameter int DROP_W = 16,
  parameter int CAP_W  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pr_valid,
  input  logic [47:0]  pr_dst_mac,
  input  logic [47:0]  pr_src_mac,
  input  logic [15:0]  pr_eth_type,
  input  logic [31:0]  pr_src_ip,
  input  logic [31:0]  pr_dst_ip,
  input  logic [7:0]   pr_protocol,
  input  logic [15:0]  pr_src_port,
  input  logic [15:0]  pr_dst_port,
  input  logic [127:0] pr_flow_key,
  input  logic         csr_wr_en,
  input  logic         csr_rd_en,
  input  logic [3:0]   csr_addr,
  input  logic [31:0]  csr_wdata,
  output logic [31:0]  csr_rdata,
  output logic         csr_rd_valid,
  output logic         snap_held,
  output logic         irq
);

  // state | meaning
  // IDLE  | disabled, parser results ignored
  // ARMED | every pr_valid overwrites the snapshot and bumps the capture counter
  // HELD  | snapshot frozen, every pr_valid bumps the saturating drop counter
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    HELD  = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic              en_q, oneshot_q, irq_en_q;
  logic [DROP_W-1:0] drop_q;
  logic [CAP_W-1:0]  cap_q;

  logic [47:0]  dst_mac_q, src_mac_q;
  logic [15:0]  eth_type_q;
  logic [31:0]  src_ip_q, dst_ip_q;
  logic [7:0]   protocol_q;
  logic [15:0]  src_port_q, dst_port_q;
  logic [127:0] flow_key_q;

  logic        ctrl_wr, en_clear, release_wr, drop_clr_wr;
  logic        capture, drop;
  logic [31:0] rd_word;

  assign ctrl_wr     = csr_wr_en && (csr_addr == 4'h1);
  assign en_clear    = ctrl_wr && !csr_wdata[0];
  assign release_wr  = ctrl_wr && csr_wdata[2];
  assign drop_clr_wr = ctrl_wr && csr_wdata[4];

  // Drops depend only on being HELD; a simultaneous release still counts the result.
  assign drop = (state_q == HELD) && pr_valid;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (en_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl_wr) state_d = ARMED;
        end
        ARMED: begin
          if (pr_valid) begin
            capture = 1'b1;
            if (oneshot_q) state_d = HELD;
          end
        end
        HELD: begin
          if (release_wr) state_d = ARMED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      snap_held <= 1'b0;
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      drop_q    <= '0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      snap_held <= (state_d == HELD);
      if (ctrl_wr) begin
        en_q      <= csr_wdata[0];
        oneshot_q <= csr_wdata[1];
      end
      if (drop_clr_wr) begin
        drop_q <= '0;
      end else if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_W'(1);
      end
      if (capture) cap_q <= cap_q + CAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_mac_q  <= '0;
      src_mac_q  <= '0;
      eth_type_q <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      protocol_q <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
      flow_key_q <= '0;
    end else if (capture) begin
      dst_mac_q  <= pr_dst_mac;
      src_mac_q  <= pr_src_mac;
      eth_type_q <= pr_eth_type;
      src_ip_q   <= pr_src_ip;
      dst_ip_q   <= pr_dst_ip;
      protocol_q <= pr_protocol;
      src_port_q <= pr_src_port;
      dst_port_q <= pr_dst_port;
      flow_key_q <= pr_flow_key;
    end
  end

`ifdef FLOW_SNAP_IRQ_EN
  logic irq_en_d;
  logic unused_wdata;

  assign irq_en_d     = ctrl_wr ? csr_wdata[3] : irq_en_q;
  assign unused_wdata = ^csr_wdata[31:5];

  // Gating with the next state/enable lets a release or IRQ_EN clear drop irq one cycle after the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq      <= snap_held && (state_d == HELD) && irq_en_d;
    end
  end
`else
  logic unused_wdata;

  assign unused_wdata = ^{csr_wdata[31:5], csr_wdata[3]};
  assign irq_en_q     = 1'b0;
  assign irq          = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (csr_addr)
      4'h0: rd_word = 32'(cap_q);
      4'h1: rd_word = {16'(drop_q), 6'b0, state_q, 4'b0, irq_en_q, 1'b0, oneshot_q, en_q};
      4'h2: rd_word = dst_mac_q[31:0];
      4'h3: rd_word = {16'h0, dst_mac_q[47:32]};
      4'h4: rd_word = src_mac_q[31:0];
      4'h5: rd_word = {16'h0, src_mac_q[47:32]};
      4'h6: rd_word = {16'h0, eth_type_q};
      4'h7: rd_word = src_ip_q;
      4'h8: rd_word = dst_ip_q;
      4'h9: rd_word = {24'h0, protocol_q};
      4'hA: rd_word = (protocol_q == 8'd17) ? {src_port_q, dst_port_q} : 32'h0;
      4'hB: rd_word = (protocol_q == 8'd6) ? {src_port_q, dst_port_q} : 32'h0;
      4'hC: rd_word = flow_key_q[31:0];
      4'hD: rd_word = flow_key_q[63:32];
      4'hE: rd_word = flow_key_q[95:64];
      4'hF: rd_word = flow_key_q[127:96];
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csr_rdata    <= '0;
      csr_rd_valid <= 1'b0;
    end else begin
      csr_rd_valid <= csr_rd_en;
      if (csr_rd_en) csr_rdata <= rd_word;
    end
  end

endmodule
